// File: rtl/race_game_if.sv
// Signal bundle between the racer game sequencer and its surroundings:
// button/collision inputs in, datapath controls and game status out.
interface race_game_if;
  logic        frame_tick;
  logic        start_btn;
  logic        collision;
  logic        rival_passed;
  logic [2:0]  state;
  logic        run_en;
  logic        restart;
  logic        car_visible;
  logic [1:0]  countdown;
  logic [13:0] score;
  logic [1:0]  lives;
  logic [2:0]  level;
  logic [5:0]  rival_period;
  logic [2:0]  scroll_step;

  modport master (
    output frame_tick, start_btn, collision, rival_passed,
    input  state, run_en, restart, car_visible, countdown,
           score, lives, level, rival_period, scroll_step
  );

  modport slave (
    input  frame_tick, start_btn, collision, rival_passed,
    output state, run_en, restart, car_visible, countdown,
           score, lives, level, rival_period, scroll_step
  );
endinterface

// File: rtl/race_game_sequencer.sv
// Racer game controller: sequences idle/countdown/run/crash/game-over and
// drives the registered datapath controls, score, lives and difficulty level.
module race_game_sequencer #(
  parameter int DIGIT_FRAMES   = 60,
  parameter int CRASH_FRAMES   = 120,
  parameter int BLINK_FRAMES   = 8,
  parameter int LIVES          = 3,
  parameter int LEVEL_UP_SCORE = 10,
  parameter int MAX_LEVEL      = 7,
  parameter int BASE_PERIOD    = 15,
  parameter int SCORE_MAX      = 9999
) (
  input logic        clk,
  input logic        rst_n,
  race_game_if.slave bus
);

  localparam int CNT_LIMIT = (DIGIT_FRAMES > CRASH_FRAMES) ? DIGIT_FRAMES : CRASH_FRAMES;
  localparam int CNT_W     = $clog2(CNT_LIMIT + 1);
  localparam int BLINK_W   = $clog2(BLINK_FRAMES + 1);
  localparam int STEP_W    = $clog2(LEVEL_UP_SCORE + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    CRASH     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t             state_q;
  logic               runEn_q;
  logic               restart_q;
  logic               carVisible_q;
  logic [1:0]         countdown_q;
  logic [13:0]        score_q;
  logic [1:0]         lives_q;
  logic [2:0]         level_q;
  logic [5:0]         rivalPeriod_q;
  logic [2:0]         scrollStep_q;
  logic [CNT_W-1:0]   frameCount_q;
  logic [BLINK_W-1:0] blinkCount_q;
  logic [STEP_W-1:0]  levelStep_q;
  logic               startPrev_q;

  logic               startEdge;
  logic [13:0]        score_d;
  logic [2:0]         level_d;
  logic [STEP_W-1:0]  levelStep_d;

  function automatic logic [5:0] rivalPeriodFor(input logic [2:0] lvl);
    return 6'(BASE_PERIOD) - {2'b00, lvl, 1'b0};
  endfunction

  function automatic logic [2:0] scrollStepFor(input logic [2:0] lvl);
    return 3'd2 + {1'b0, lvl[2:1]};
  endfunction

  assign startEdge = bus.start_btn & ~startPrev_q;

  // levelStep_q tracks score modulo LEVEL_UP_SCORE, so no divider is needed
  always_comb begin
    score_d     = score_q;
    level_d     = level_q;
    levelStep_d = levelStep_q;
    if (score_q < 14'(SCORE_MAX)) begin
      score_d = score_q + 14'd1;
      if (levelStep_q == STEP_W'(LEVEL_UP_SCORE - 1)) begin
        levelStep_d = '0;
        if (level_q < 3'(MAX_LEVEL)) begin
          level_d = level_q + 3'd1;
        end
      end else begin
        levelStep_d = levelStep_q + STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      runEn_q       <= 1'b0;
      restart_q     <= 1'b0;
      carVisible_q  <= 1'b1;
      countdown_q   <= 2'd0;
      score_q       <= 14'd0;
      lives_q       <= 2'(LIVES);
      level_q       <= 3'd0;
      rivalPeriod_q <= 6'(BASE_PERIOD);
      scrollStep_q  <= 3'd2;
      frameCount_q  <= '0;
      blinkCount_q  <= '0;
      levelStep_q   <= '0;
      startPrev_q   <= 1'b1;
    end else begin
      startPrev_q <= bus.start_btn;
      restart_q   <= 1'b0;
      case (state_q)
        IDLE, GAME_OVER: begin
          runEn_q <= 1'b0;
          if (startEdge) begin
            score_q       <= 14'd0;
            levelStep_q   <= '0;
            lives_q       <= 2'(LIVES);
            level_q       <= 3'd0;
            rivalPeriod_q <= 6'(BASE_PERIOD);
            scrollStep_q  <= 3'd2;
            restart_q     <= 1'b1;
            countdown_q   <= 2'd3;
            frameCount_q  <= '0;
            state_q       <= COUNTDOWN;
          end
        end

        COUNTDOWN: begin
          if (bus.frame_tick) begin
            if (frameCount_q == CNT_W'(DIGIT_FRAMES - 1)) begin
              frameCount_q <= '0;
              if (countdown_q == 2'd1) begin
                countdown_q <= 2'd0;
                runEn_q     <= 1'b1;
                state_q     <= RUN;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              frameCount_q <= frameCount_q + CNT_W'(1);
            end
          end
        end

        RUN: begin
          if (bus.collision) begin
            lives_q      <= lives_q - 2'd1;
            frameCount_q <= '0;
            blinkCount_q <= '0;
            carVisible_q <= 1'b0;
            runEn_q      <= 1'b0;
            state_q      <= CRASH;
          end else if (bus.rival_passed) begin
            score_q       <= score_d;
            levelStep_q   <= levelStep_d;
            level_q       <= level_d;
            rivalPeriod_q <= rivalPeriodFor(level_d);
            scrollStep_q  <= scrollStepFor(level_d);
          end
        end

        CRASH: begin
          if (bus.frame_tick) begin
            if (frameCount_q == CNT_W'(CRASH_FRAMES - 1)) begin
              frameCount_q <= '0;
              carVisible_q <= 1'b1;
              if (lives_q == 2'd0) begin
                state_q <= GAME_OVER;
              end else begin
                restart_q   <= 1'b1;
                countdown_q <= 2'd3;
                state_q     <= COUNTDOWN;
              end
            end else begin
              frameCount_q <= frameCount_q + CNT_W'(1);
              if (blinkCount_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blinkCount_q <= '0;
                carVisible_q <= ~carVisible_q;
              end else begin
                blinkCount_q <= blinkCount_q + BLINK_W'(1);
              end
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          runEn_q     <= 1'b0;
          countdown_q <= 2'd0;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.run_en       = runEn_q;
  assign bus.restart      = restart_q;
  assign bus.car_visible  = carVisible_q;
  assign bus.countdown    = countdown_q;
  assign bus.score        = score_q;
  assign bus.lives        = lives_q;
  assign bus.level        = level_q;
  assign bus.rival_period = rivalPeriod_q;
  assign bus.scroll_step  = scrollStep_q;

endmodule

// File: doc/race_game_sequencer.md
# race_game_sequencer

Top-level game controller for the racer display pipeline. Sequences a play session through idle, countdown, running, crash and game-over phases, and generates the datapath controls consumed by the sprite/scroll logic:
- a frame-advance enable;
- a one-cycle datapath restart pulse;
- difficulty settings (rival step period, scroll step).

It also keeps score, lives and level. It sits between the debounced buttons and collision detector on one side and the scroll/rival/car position registers on the other.

## Interface
Parameters:
- DIGIT_FRAMES, 60, frames each countdown digit (3,2,1) is shown
- CRASH_FRAMES, 120, frames spent in CRASH before resolving
- BLINK_FRAMES, 8, frames per car_visible toggle in CRASH
- LIVES, 3, lives at session start (1..3)
- LEVEL_UP_SCORE, 10, score increments per level step
- MAX_LEVEL, 7, highest level
- BASE_PERIOD, 15, rival step period at level 0 (must be ≥ 2*MAX_LEVEL+1)
- SCORE_MAX, 9999, score saturation value

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at end of each VGA frame
- start_btn  in  1  debounced start level; internal rising-edge detect
- collision  in  1  level, main car overlapping rival or road edge
- rival_passed  in  1  one-cycle pulse when a rival respawns uncollided
- state  out  3  0 IDLE, 1 COUNTDOWN, 2 RUN, 3 CRASH, 4 GAME_OVER
- run_en  out  1  high only in RUN; gates scroll/rival/car advance
- restart  out  1  one-cycle pulse: reset car, rival, scroll registers
- car_visible  out  1  main-car sprite enable
- countdown  out  2  digit shown in COUNTDOWN (3,2,1), else 0
- score  out  14  binary score
- lives  out  2  remaining lives
- level  out  3  current difficulty level
- rival_period  out  6  BASE_PERIOD − 2*level
- scroll_step  out  3  2 + (level >> 1)

## Operation
**Start detection**
- start_edge = start_btn & ~start_prev.
- start_prev resets to 1, so a button held through reset does not start a game.

**IDLE**
- run_en = 0.
- On start_edge: score ← 0, lives ← LIVES, level ← 0, pulse restart, go to COUNTDOWN with countdown ← 3 and frame counter ← 0.

**COUNTDOWN**
- collision and rival_passed are ignored.
- On each frame_tick the frame counter increments.
- When it reaches DIGIT_FRAMES−1 at a frame_tick: counter ← 0 and countdown decrements.
- A frame_tick that ends digit 1 sets countdown ← 0 and moves to RUN.

**RUN**
- run_en = 1.
- collision high in any cycle: lives ← lives−1, counter ← 0, go to CRASH.
- Otherwise, rival_passed: score ← min(score+1, SCORE_MAX).
  - If the new score is a nonzero multiple of LEVEL_UP_SCORE and level < MAX_LEVEL, then level ← level+1.
  - Score is not incremented once saturated; level does not change then either.
- Simultaneous collision and rival_passed: collision wins; score is unchanged.

**CRASH**
- run_en = 0.
- car_visible toggles on every BLINK_FRAMES-th frame_tick, starting low on entry.
- On the frame_tick where the counter reaches CRASH_FRAMES−1:
  - If lives == 0: go to GAME_OVER.
  - Else: pulse restart and go to COUNTDOWN (countdown ← 3). Score and level are kept.
- car_visible ← 1 on exit.

**GAME_OVER**
- run_en = 0; score, level and lives are frozen.
- start_edge behaves exactly as in IDLE.

**General**
- Undefined state encodings go to IDLE on the next clock.
- rival_period and scroll_step are registered functions of level; the arithmetic never underflows, given the BASE_PERIOD constraint.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N.
- restart is high for exactly the first cycle in COUNTDOWN. It never asserts twice for one transition.
- run_en rises in the same cycle state becomes RUN, and falls in the same cycle state leaves RUN. No extra advance frame occurs after a collision.
- frame_tick and the state change are evaluated in the same cycle. The last COUNTDOWN frame_tick does not itself advance RUN datapath registers.
- Reset values:
  - state: IDLE
  - run_en: 0
  - restart: 0
  - car_visible: 1
  - countdown: 0
  - score: 0
  - lives: LIVES
  - level: 0
  - rival_period: BASE_PERIOD
  - scroll_step: 2
- rst_n asserted mid-game forces all reset values immediately (asynchronously). No restart pulse is generated.

## Test plan
- **Reset/start:** release rst_n with start_btn held high → remains IDLE. Release and press start → restart pulses 1 cycle, state=1, countdown=3.
- **Countdown:** after start, 180 frame_ticks (DIGIT_FRAMES=60) → countdown steps 3→2→1 at ticks 60 and 120. state=2 and run_en=1 after tick 180.
- **Scoring/levels:** in RUN, 10 rival_passed pulses → score=10, level=1, rival_period=13, scroll_step=2. At 20 → level=2, scroll_step=3.
- **Simultaneous events:** collision and rival_passed in the same cycle with score=5, lives=3 → state=3, lives=2, score=5, run_en=0 next cycle.
- **Crash resolution:**
  - lives=2 → after 120 frame_ticks, restart pulses and state=1; score is kept.
  - car_visible toggles every 8 ticks.
  - Third crash (lives=0) → state=4. start_edge then gives score=0, lives=3.
- **Async reset mid-RUN:** drop rst_n with score=37, level=3 → all outputs return to reset values without waiting for clk. No restart pulse.
